reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised successor to the 16x16 structural register bank: NUM_REGS x DATA_W storage, two async read
//  ports, two write-back ports (ALU and memory), optional write-to-read bypass, optional hardwired-zero reg 0.
//  Adds a per-register busy scoreboard (pending-write tracking) consumed by the decode/stall logic.
//  Sits between decode (read addrs, busy_set) and the ALU/memory write-back stages.
// PARAMETERS
//  DATA_W    16                 register width in bits
//  NUM_REGS  16                 number of registers (>=2)
//  ADDR_W    $clog2(NUM_REGS)   register address width
//  ZERO_REG  0                  1: reg 0 reads 0, writes and busy_set to it ignored
//  BYPASS    1                  1: same-cycle write data forwarded to read ports
// PORTS
//  clk           in   1          rising-edge clock
//  reset         in   1          synchronous, active-high
//  ra_addr       in   ADDR_W     read port A address
//  ra_data       out  DATA_W     read port A data (combinational)
//  ra_busy       out  1          reg at ra_addr has pending write
//  rb_addr       in   ADDR_W     read port B address
//  rb_data       out  DATA_W     read port B data (combinational)
//  rb_busy       out  1          reg at rb_addr has pending write
//  wa_en         in   1          ALU write-back enable
//  wa_addr       in   ADDR_W     ALU write-back address
//  wa_data       in   DATA_W     ALU write-back data
//  wm_en         in   1          memory write-back enable
//  wm_addr       in   ADDR_W     memory write-back address
//  wm_data       in   DATA_W     memory write-back data
//  busy_set      in   1          mark busy_addr pending (instruction issued)
//  busy_addr     in   ADDR_W     destination being marked pending
//  busy_vec      out  NUM_REGS   registered busy bits, bit i = reg i
//  wr_collision  out  1          registered pulse: wa/wm hit same addr last cycle
// BEHAVIOUR
//  Reset: on clk edge with reset=1, all regs <= 0, busy_vec <= 0, wr_collision <= 0; reset overrides
//   every write, busy_set and clear in that cycle.
//  Write: regs update on clk edge; 1-cycle latency to array. Addr >= NUM_REGS: write ignored.
//  Dual write same addr, same cycle: wm (memory) wins; wa dropped; wr_collision = 1 next cycle only.
//  Read: ra_data = array[ra_addr], 0-cycle. BYPASS=1 and write enabled to ra_addr this cycle ->
//   forward write data (wm over wa per above). Same for rb. BYPASS=0: old value until next cycle.
//  ZERO_REG=1: reads of addr 0 return 0 regardless of bypass; writes to 0 dropped, no collision flag.
//  Out-of-range read addr: data 0, busy 0.
//  Scoreboard: busy[i] set when busy_set && busy_addr==i; cleared when wa_en or wm_en writes i.
//   Set and clear same reg same cycle: set wins (busy stays 1). busy_set to an already-busy reg: stays 1.
//  ra_busy = busy[ra_addr], except BYPASS=1 and a write to ra_addr this cycle -> 0 (data forwarded);
//   a same-cycle busy_set is not visible on ra_busy until next cycle. Same for rb_busy.
//  No stall/backpressure generated here; decode must honour ra_busy/rb_busy.
// STRUCTURE
//  Shared include regfile_defs.vh: default DATA_W/NUM_REGS, write-port priority constant (WM over WA).
//  Sub-module reg_scoreboard: busy bit vector, set/clear/priority, busy lookup for two read addrs.
//  Storage: reg array DATA_W x NUM_REGS in top; bypass muxes in top.
// TESTING
//  1 reset 2 cycles, then read all addrs -> every ra_data/rb_data 0, busy_vec 0, wr_collision 0.
//  2 wa_en addr 3 data 0xBEEF, ra_addr=3 same cycle -> ra_data 0xBEEF (BYPASS=1), 0x0000 (BYPASS=0);
//    next cycle 0xBEEF both.
//  3 wa(5,0x1111) and wm(5,0x2222) same cycle -> reg5=0x2222, wr_collision 1 for exactly one cycle.
//  4 busy_set 7; next cycle busy_vec[7]=1, rb_busy=1 at rb_addr=7; wm write 7 + busy_set 7 same
//    cycle -> busy_vec[7] stays 1; later wa write 7 alone -> 0.
//  5 ZERO_REG=1: wa(0,0xFFFF), busy_set 0 -> ra_data(0)=0, busy_vec[0]=0, no collision.
//  6 reset asserted same cycle as wa(2,0x1234) and busy_set 2 -> reg2=0, busy_vec 0 next cycle.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared defaults and write-port priority for the register file
package reg_file_sb_pkg;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;
  typedef enum logic {WP_WA, WP_WM} wr_port_e;
  localparam wr_port_e WR_PRIO = WP_WM;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_file_sb_scoreboard: per-register pending-write bits with busy lookup for two read ports
module reg_file_sb_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_set,
  input  logic [ADDR_W-1:0]   i_set_addr,
  input  logic                i_clr_a,
  input  logic [ADDR_W-1:0]   i_clr_a_addr,
  input  logic                i_clr_b,
  input  logic [ADDR_W-1:0]   i_clr_b_addr,
  input  logic [ADDR_W-1:0]   i_ra_addr,
  input  logic [ADDR_W-1:0]   i_rb_addr,
  input  logic                i_ra_hide,
  input  logic                i_rb_hide,
  output logic [NUM_REGS-1:0] o_busy_vec,
  output logic                o_ra_busy,
  output logic                o_rb_busy
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_next;
  // clears from retiring writes first, then a new issue re-marks so set wins
  always_comb begin
    w_next = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_clr_a && 32'(i_clr_a_addr) == i) w_next[i] = 1'b0;
      if (i_clr_b && 32'(i_clr_b_addr) == i) w_next[i] = 1'b0;
      if (i_set && 32'(i_set_addr) == i) w_next[i] = 1'b1;
    end
  end
  // busy bit register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_busy <= '0;
    else r_busy <= w_next;
  end
  assign o_busy_vec = r_busy;
  assign o_ra_busy  = 32'(i_ra_addr) < NUM_REGS && r_busy[i_ra_addr] && !i_ra_hide;
  assign o_rb_busy  = 32'(i_rb_addr) < NUM_REGS && r_busy[i_rb_addr] && !i_rb_hide;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/2-write register file with optional bypass, zero register and busy scoreboard
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [ADDR_W-1:0]   i_ra_addr,
  output logic [DATA_W-1:0]   o_ra_data,
  output logic                o_ra_busy,
  input  logic [ADDR_W-1:0]   i_rb_addr,
  output logic [DATA_W-1:0]   o_rb_data,
  output logic                o_rb_busy,
  input  logic                i_wa_en,
  input  logic [ADDR_W-1:0]   i_wa_addr,
  input  logic [DATA_W-1:0]   i_wa_data,
  input  logic                i_wm_en,
  input  logic [ADDR_W-1:0]   i_wm_addr,
  input  logic [DATA_W-1:0]   i_wm_data,
  input  logic                i_busy_set,
  input  logic [ADDR_W-1:0]   i_busy_addr,
  output logic [NUM_REGS-1:0] o_busy_vec,
  output logic                o_wr_collision
);
  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic r_coll;
  logic w_wa_ok, w_wm_ok, w_coll, w_wa_eff, w_wm_eff, w_set;
  logic w_ra_fa, w_ra_fm, w_rb_fa, w_rb_fm;
  // an address is usable when it exists and is not the hardwired zero register
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS && !(ZERO_REG != 0 && a == '0);
  endfunction
  assign w_wa_ok  = i_wa_en && addr_ok(i_wa_addr);
  assign w_wm_ok  = i_wm_en && addr_ok(i_wm_addr);
  assign w_coll   = w_wa_ok && w_wm_ok && i_wa_addr == i_wm_addr;
  assign w_wa_eff = w_wa_ok && !(w_coll && WR_PRIO == WP_WM);
  assign w_wm_eff = w_wm_ok && !(w_coll && WR_PRIO == WP_WA);
  assign w_set    = i_busy_set && addr_ok(i_busy_addr);
  assign w_ra_fa  = BYPASS != 0 && w_wa_eff && i_wa_addr == i_ra_addr;
  assign w_ra_fm  = BYPASS != 0 && w_wm_eff && i_wm_addr == i_ra_addr;
  assign w_rb_fa  = BYPASS != 0 && w_wa_eff && i_wa_addr == i_rb_addr;
  assign w_rb_fm  = BYPASS != 0 && w_wm_eff && i_wm_addr == i_rb_addr;
  // storage update and one-cycle collision flag; colliding writes were already resolved above
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      r_coll <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wm_eff && 32'(i_wm_addr) == i) r_mem[i] <= i_wm_data;
        else if (w_wa_eff && 32'(i_wa_addr) == i) r_mem[i] <= i_wa_data;
      end
      r_coll <= w_coll;
    end
  end
  // read muxes: unusable address reads 0, otherwise forwarded write data beats the array
  always_comb begin
    o_ra_data = !addr_ok(i_ra_addr) ? '0 : w_ra_fm ? i_wm_data : w_ra_fa ? i_wa_data : r_mem[i_ra_addr];
    o_rb_data = !addr_ok(i_rb_addr) ? '0 : w_rb_fm ? i_wm_data : w_rb_fa ? i_wa_data : r_mem[i_rb_addr];
  end
  assign o_wr_collision = r_coll;
  reg_file_sb_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_set        (w_set),
    .i_set_addr   (i_busy_addr),
    .i_clr_a      (w_wa_ok),
    .i_clr_a_addr (i_wa_addr),
    .i_clr_b      (w_wm_ok),
    .i_clr_b_addr (i_wm_addr),
    .i_ra_addr    (i_ra_addr),
    .i_rb_addr    (i_rb_addr),
    .i_ra_hide    (w_ra_fa || w_ra_fm),
    .i_rb_hide    (w_rb_fa || w_rb_fm),
    .o_busy_vec   (o_busy_vec),
    .o_ra_busy    (o_ra_busy),
    .o_rb_busy    (o_rb_busy)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: vector table plus hand sequences for the default and zero-reg/no-bypass builds
module tb_reg_file_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, wa_en, wm_en, bs;
  logic [3:0] wa_addr, wm_addr, bs_addr, ra, rb;
  logic [15:0] wa_data, wm_data;
  logic [15:0] d_ra, d_rb, d_bv, z_ra, z_rb;
  logic d_rab, d_rbb, d_col, z_rab, z_rbb, z_col;
  logic [11:0] z_bv;
  int checks = 0;
  int errors = 0;
  reg_file_sb u_dut (
    .i_clk(clk), .i_reset(rst),
    .i_ra_addr(ra), .o_ra_data(d_ra), .o_ra_busy(d_rab),
    .i_rb_addr(rb), .o_rb_data(d_rb), .o_rb_busy(d_rbb),
    .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wm_en(wm_en), .i_wm_addr(wm_addr), .i_wm_data(wm_data),
    .i_busy_set(bs), .i_busy_addr(bs_addr),
    .o_busy_vec(d_bv), .o_wr_collision(d_col)
  );
  reg_file_sb #(.NUM_REGS(12), .ZERO_REG(1), .BYPASS(0)) u_dz (
    .i_clk(clk), .i_reset(rst),
    .i_ra_addr(ra), .o_ra_data(z_ra), .o_ra_busy(z_rab),
    .i_rb_addr(rb), .o_rb_data(z_rb), .o_rb_busy(z_rbb),
    .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wm_en(wm_en), .i_wm_addr(wm_addr), .i_wm_data(wm_data),
    .i_busy_set(bs), .i_busy_addr(bs_addr),
    .o_busy_vec(z_bv), .o_wr_collision(z_col)
  );
  typedef struct {
    logic rst, wa_en; logic [3:0] wa_addr; logic [15:0] wa_data;
    logic wm_en; logic [3:0] wm_addr; logic [15:0] wm_data;
    logic bs; logic [3:0] bs_addr; logic [3:0] ra, rb;
    logic [15:0] e_ra; logic e_rab; logic [15:0] e_rb; logic e_rbb;
    logic [15:0] e_bv; logic e_col;
  } vec_t;
  typedef struct { logic [15:0] bv; logic col; int idx; } reg_exp_t;
  localparam int NV = 18;
  vec_t tbl [NV];
  reg_exp_t q [$];
  function automatic vec_t mk(input logic r, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                              input logic me, input logic [3:0] ma, input logic [15:0] md,
                              input logic s, input logic [3:0] sa, input logic [3:0] a, input logic [3:0] b,
                              input logic [15:0] ea, input logic eab, input logic [15:0] eb, input logic ebb,
                              input logic [15:0] ev, input logic ec);
    vec_t v;
    v.rst = r; v.wa_en = we; v.wa_addr = wa; v.wa_data = wd;
    v.wm_en = me; v.wm_addr = ma; v.wm_data = md; v.bs = s; v.bs_addr = sa;
    v.ra = a; v.rb = b; v.e_ra = ea; v.e_rab = eab; v.e_rb = eb; v.e_rbb = ebb;
    v.e_bv = ev; v.e_col = ec;
    return v;
  endfunction
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic idle();
    rst = 0; wa_en = 0; wa_addr = 0; wa_data = 0; wm_en = 0; wm_addr = 0; wm_data = 0;
    bs = 0; bs_addr = 0; ra = 0; rb = 0;
  endtask
  task automatic apply(input vec_t v);
    rst = v.rst; wa_en = v.wa_en; wa_addr = v.wa_addr; wa_data = v.wa_data;
    wm_en = v.wm_en; wm_addr = v.wm_addr; wm_data = v.wm_data;
    bs = v.bs; bs_addr = v.bs_addr; ra = v.ra; rb = v.rb;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reg_exp_t r;
    tbl[0]  = mk(0, 1, 3, 'hBEEF, 0, 0, 0,       0, 0, 3, 3,  'hBEEF, 0, 'hBEEF, 0, 'h0000, 0);
    tbl[1]  = mk(0, 0, 0, 0,      0, 0, 0,       0, 0, 3, 0,  'hBEEF, 0, 'h0000, 0, 'h0000, 0);
    tbl[2]  = mk(0, 1, 5, 'h1111, 1, 5, 'h2222, 0, 0, 5, 3,  'h2222, 0, 'hBEEF, 0, 'h0000, 1);
    tbl[3]  = mk(0, 0, 0, 0,      0, 0, 0,       0, 0, 5, 5,  'h2222, 0, 'h2222, 0, 'h0000, 0);
    tbl[4]  = mk(0, 0, 0, 0,      0, 0, 0,       1, 7, 7, 7,  'h0000, 0, 'h0000, 0, 'h0080, 0);
    tbl[5]  = mk(0, 0, 0, 0,      0, 0, 0,       0, 0, 7, 7,  'h0000, 1, 'h0000, 1, 'h0080, 0);
    tbl[6]  = mk(0, 0, 0, 0,      1, 7, 'h7777, 1, 7, 7, 3,  'h7777, 0, 'hBEEF, 0, 'h0080, 0);
    tbl[7]  = mk(0, 0, 0, 0,      0, 0, 0,       0, 0, 7, 7,  'h7777, 1, 'h7777, 1, 'h0080, 0);
    tbl[8]  = mk(0, 1, 7, 'hAAAA, 0, 0, 0,       1, 9, 7, 9,  'hAAAA, 0, 'h0000, 0, 'h0200, 0);
    tbl[9]  = mk(0, 0, 0, 0,      0, 0, 0,       0, 0, 7, 9,  'hAAAA, 0, 'h0000, 1, 'h0200, 0);
    tbl[10] = mk(0, 1, 9, 'h0909, 1, 2, 'h2020, 0, 0, 9, 2,  'h0909, 0, 'h2020, 0, 'h0000, 0);
    tbl[11] = mk(1, 1, 2, 'h1234, 0, 0, 0,       1, 2, 9, 9,  'h0909, 0, 'h0909, 0, 'h0000, 0);
    tbl[12] = mk(0, 0, 0, 0,      0, 0, 0,       0, 0, 2, 9,  'h0000, 0, 'h0000, 0, 'h0000, 0);
    tbl[13] = mk(0, 1, 4, 'h4444, 1, 6, 'h6666, 1, 4, 4, 6,  'h4444, 0, 'h6666, 0, 'h0010, 0);
    tbl[14] = mk(0, 0, 0, 0,      0, 0, 0,       0, 0, 4, 6,  'h4444, 1, 'h6666, 0, 'h0010, 0);
    tbl[15] = mk(0, 1, 15, 'hFFFF, 0, 0, 0,      0, 0, 15, 0, 'hFFFF, 0, 'h0000, 0, 'h0010, 0);
    tbl[16] = mk(0, 0, 0, 0,      1, 0, 'h0D0D, 0, 0, 0, 15, 'h0D0D, 0, 'hFFFF, 0, 'h0010, 0);
    tbl[17] = mk(0, 0, 0, 0,      0, 0, 0,       0, 0, 0, 4,  'h0D0D, 0, 'h4444, 1, 'h0010, 0);
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i); rb = 4'(15 - i);
      #1;
      chk($sformatf("rst ra_data[%0d]", i), d_ra, 0);
      chk($sformatf("rst rb_data[%0d]", 15 - i), d_rb, 0);
      chk($sformatf("rst busy[%0d]", i), {14'd0, d_rab, d_rbb}, 0);
      chk($sformatf("rst z ra_data[%0d]", i), z_ra, 0);
    end
    chk("rst busy_vec", d_bv, 0);
    chk("rst wr_collision", {15'd0, d_col}, 0);
    chk("rst z busy_vec", {4'd0, z_bv}, 0);
    for (int k = 0; k < NV; k++) begin
      apply(tbl[k]);
      #2;
      chk($sformatf("v%0d ra_data", k), d_ra, tbl[k].e_ra);
      chk($sformatf("v%0d ra_busy", k), {15'd0, d_rab}, {15'd0, tbl[k].e_rab});
      chk($sformatf("v%0d rb_data", k), d_rb, tbl[k].e_rb);
      chk($sformatf("v%0d rb_busy", k), {15'd0, d_rbb}, {15'd0, tbl[k].e_rbb});
      q.push_back('{tbl[k].e_bv, tbl[k].e_col, k});
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d scoreboard: got empty queue expected entry", k);
      end else begin
        r = q.pop_front();
        chk($sformatf("v%0d busy_vec", r.idx), d_bv, r.bv);
        chk($sformatf("v%0d wr_collision", r.idx), {15'd0, d_col}, {15'd0, r.col});
      end
    end
    idle(); rst = 1; tick(); rst = 0;
    wa_en = 1; wa_addr = 3; wa_data = 'hBEEF; ra = 3;
    #1;
    chk("nobyp same-cycle ra_data", z_ra, 'h0000);
    chk("byp same-cycle ra_data", d_ra, 'hBEEF);
    tick(); idle(); ra = 3; #1;
    chk("nobyp next ra_data", z_ra, 'hBEEF);
    chk("byp next ra_data", d_ra, 'hBEEF);
    wa_en = 1; wa_addr = 0; wa_data = 'hFFFF; wm_en = 1; wm_addr = 0; wm_data = 'h1234;
    bs = 1; bs_addr = 0; ra = 0;
    #1;
    chk("zero same-cycle ra_data", z_ra, 'h0000);
    chk("reg0 same-cycle ra_data", d_ra, 'h1234);
    tick(); idle(); ra = 0; #1;
    chk("zero ra_data", z_ra, 'h0000);
    chk("zero busy_vec", {4'd0, z_bv}, 0);
    chk("zero wr_collision", {15'd0, z_col}, 0);
    chk("reg0 ra_data", d_ra, 'h1234);
    chk("reg0 busy_vec", d_bv, 'h0001);
    chk("reg0 wr_collision", {15'd0, d_col}, 1);
    tick();
    chk("reg0 wr_collision drop", {15'd0, d_col}, 0);
    bs = 1; bs_addr = 13; wa_en = 1; wa_addr = 13; wa_data = 'h5555; ra = 13; rb = 13;
    #1;
    chk("oor same-cycle ra_data", z_ra, 'h0000);
    chk("oor same-cycle ra_busy", {15'd0, z_rab}, 0);
    tick(); idle(); ra = 13; #1;
    chk("oor busy_vec", {4'd0, z_bv}, 0);
    chk("oor ra_data", z_ra, 'h0000);
    chk("oor ra_busy", {15'd0, z_rab}, 0);
    chk("r13 ra_data", d_ra, 'h5555);
    chk("r13 ra_busy", {15'd0, d_rab}, 1);
    chk("r13 busy_vec", d_bv, 'h2001);
    bs = 1; bs_addr = 8;
    tick(); idle();
    wa_en = 1; wa_addr = 8; wa_data = 'h8888; ra = 8;
    #1;
    chk("nobyp busy kept", {15'd0, z_rab}, 1);
    chk("nobyp old data", z_ra, 'h0000);
    chk("byp busy hidden", {15'd0, d_rab}, 0);
    chk("byp fwd data", d_ra, 'h8888);
    tick(); idle(); ra = 8; #1;
    chk("nobyp busy cleared", {15'd0, z_rab}, 0);
    chk("nobyp new data", z_ra, 'h8888);
    chk("nobyp busy_vec", {4'd0, z_bv}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
